bit_count_fsm: RTL and testbench
================================

// Module: bit_count_fsm
// PURPOSE
//   Start-triggered population counter. On start it captures a WIDTH-bit word d,
//   then scans it LSB-first, one bit per clock, counting the ones into out.
//   After all WIDTH bits are scanned it raises done and holds the result until restarted.
//   Used as a small control/datapath block; start/done form the handshake.
// PARAMETERS
//   WIDTH  16                   data word width, bits scanned per operation
//   CNT_W  $clog2(WIDTH+1) (5)  width of out; must hold the value WIDTH
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      level: 1 = (re)load d and hold in S0; falling to 0 starts scan
//   d      in   WIDTH  data word; sampled every cycle the FSM is in S0
//   out    out  CNT_W  running / final count of ones in captured word
//   done   out  1      1 while in DONE (result valid), else 0
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low.
//   Reset (rst_n=0, any time incl. mid-scan): state=IDLE, out=0, done=0,
//     shift reg=0, bit index=0. Leaving reset needs no start pulse timing.
//   States (Moore, all registered; outputs change only on clk edge or reset):
//   - IDLE: done=0, out holds. start=1 -> S0.
//   - S0: each cycle sh<=d, idx<=0, out<=0, done=0. start=1 -> stay S0
//     (d re-sampled each cycle, last value before start falls wins); start=0 -> RUN.
//   - RUN: each cycle out<=out+sh[0], sh<=sh>>1, idx<=idx+1.
//     When idx==WIDTH-1 (last bit processed this cycle) -> DONE.
//     start=1 in RUN: abort, -> S0 (counting of that cycle discarded).
//   - DONE: done=1, out holds final count. start=1 -> S0 (done drops next edge);
//     else stay DONE indefinitely.
//   Latency: first edge with start=0 in S0 -> RUN; exactly WIDTH RUN cycles later
//     state=DONE, done=1 and out=popcount(d). Scan length fixed (no early exit on zero).
//   out increments by at most 1 per cycle, never exceeds WIDTH, no wrap.
//   d changes outside S0 have no effect on the current scan.
//   Illegal/unused state encodings recover to IDLE on next clock.
// TESTING (clk period 20 ns)
//   1 rst_n=0 then 1, start=0 -> IDLE, out=0, done=0 stays for any d.
//   2 d=16'h7F80, start=1 two cycles then 0 -> out rises 0..8 during RUN
//     (bits 7..14), DONE 16 cycles after RUN entry: out=8, done=1, holds.
//   3 From DONE: start=1 five cycles, d=16'h0000 on release -> done=0 next edge,
//     out=0; after 16 RUN cycles done=1, out=0.
//   4 d=16'hFFFF full scan -> out=16 (max, no overflow), done=1.
//   5 start=1 mid-RUN (cycle 5) -> S0, out=0; release with d=16'h0001 -> out=1, done=1.
//   6 rst_n=0 mid-RUN -> immediately out=0, done=0, IDLE, without waiting for clk.

Source files
------------

// File: rtl/bit_count_fsm.sv
// bit_count_fsm: start-triggered LSB-first population counter, one bit per clock
module bit_count_fsm #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic [CNT_W-1:0] out,
  output logic             done
);
  localparam int IDX_W = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, S0, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] out_n;
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    out_n = out;
    case (state)
      IDLE: state_n = start ? S0 : IDLE;
      S0: begin
        sh_n = d;
        idx_n = '0;
        out_n = '0;
        state_n = start ? S0 : RUN;
      end
      RUN: begin
        // an abort discards this cycle's bit; S0 clears the count next edge
        if (start) state_n = S0;
        else begin
          out_n = out + {{(CNT_W-1){1'b0}}, sh[0]};
          sh_n = sh >> 1;
          idx_n = idx + 1'b1;
          state_n = (idx == IDX_W'(WIDTH - 1)) ? DONE : RUN;
        end
      end
      DONE: state_n = start ? S0 : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      out <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      out <= out_n;
      done <= (state_n == DONE);
    end
  end
endmodule

// File: tb/tb_bit_count_fsm.sv
// tb_bit_count_fsm: directed vectors and corner-case sequences for bit_count_fsm
module tb_bit_count_fsm;
  logic clk, rst_n, start;
  logic [15:0] d;
  logic [4:0] out;
  logic done;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] d;
    int exp;
  } vec_t;
  vec_t vecs[6];

  bit_count_fsm dut (.clk(clk), .rst_n(rst_n), .start(start), .d(d), .out(out), .done(done));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic scan(input logic [15:0] dv, input int exp, input string nm);
    start = 1'b1;
    d = dv;
    tick;
    tick;
    chk({nm, " s0 out"}, out, 0);
    chk({nm, " s0 done"}, done, 0);
    start = 1'b0;
    tick;
    d = ~dv;
    repeat (15) tick;
    chk({nm, " early done"}, done, 0);
    tick;
    chk({nm, " out"}, out, exp);
    chk({nm, " done"}, done, 1);
    repeat (3) tick;
    chk({nm, " hold out"}, out, exp);
    chk({nm, " hold done"}, done, 1);
  endtask

  initial begin
    vecs[0] = '{16'h7F80, 8};
    vecs[1] = '{16'h0000, 0};
    vecs[2] = '{16'hFFFF, 16};
    vecs[3] = '{16'h0001, 1};
    vecs[4] = '{16'hA5A5, 8};
    vecs[5] = '{16'h1234, 5};
    rst_n = 1'b0;
    start = 1'b0;
    d = 16'h0000;
    tick;
    tick;
    rst_n = 1'b1;
    chk("reset out", out, 0);
    chk("reset done", done, 0);
    for (int i = 0; i < 4; i++) begin
      d = 16'hFFFF ^ 16'(i * 16'h1111);
      tick;
      chk("idle out", out, 0);
      chk("idle done", done, 0);
    end
    // 7F80: count climbs only across bits 7..14
    start = 1'b1;
    d = 16'h7F80;
    tick;
    tick;
    start = 1'b0;
    tick;
    chk("ramp entry out", out, 0);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk($sformatf("ramp out k=%0d", k), out, (k <= 7) ? 0 : (k >= 15 ? 8 : k - 7));
      chk($sformatf("ramp done k=%0d", k), done, (k == 16) ? 1 : 0);
    end
    // restart from DONE with a long start pulse
    start = 1'b1;
    d = 16'hFFFF;
    tick;
    chk("restart done drop", done, 0);
    tick;
    chk("restart out clear", out, 0);
    tick;
    tick;
    d = 16'h0000;
    tick;
    start = 1'b0;
    tick;
    repeat (15) tick;
    chk("restart early done", done, 0);
    tick;
    chk("restart out", out, 0);
    chk("restart done", done, 1);
    for (int i = 0; i < 6; i++) scan(vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
    // abort mid-RUN
    start = 1'b1;
    d = 16'hFFFF;
    tick;
    tick;
    start = 1'b0;
    tick;
    repeat (5) tick;
    chk("pre-abort out", out, 5);
    start = 1'b1;
    d = 16'h0001;
    tick;
    chk("abort done", done, 0);
    tick;
    chk("abort out", out, 0);
    start = 1'b0;
    tick;
    repeat (16) tick;
    chk("post-abort out", out, 1);
    chk("post-abort done", done, 1);
    // asynchronous reset mid-RUN
    start = 1'b1;
    d = 16'hFFFF;
    tick;
    start = 1'b0;
    tick;
    repeat (6) tick;
    chk("pre-reset out", out, 6);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async reset out", out, 0);
    chk("async reset done", done, 0);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (20) tick;
    chk("post-reset out", out, 0);
    chk("post-reset done", done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
